// File: rtl/pipe_stage_fifo.sv
// -----------------------------------------------------------------------------
// pipe_stage_fifo
//
// Small elastic buffer placed between two pipeline stages. It holds up to DEPTH
// payload words and passes them on in arrival order. The buffer supports a
// flush for branch redirects. It also tracks the peak occupancy seen since
// reset or since the last hwm_clr.
//
// Ports
//   clock     : single clock; all state changes on its rising edge
//   reset     : asynchronous, active-low reset of all control state
//   in_valid  : upstream presents a word
//   in_data   : upstream payload (WIDTH bits)
//   in_ready  : buffer has room; depends only on registered occupancy
//   out_valid : head entry is valid
//   out_data  : head entry payload, driven from the storage registers
//   out_ready : downstream consumes the head entry this cycle
//   flush     : discard all held entries; overrides any push or pop
//   count     : current number of valid entries (CW bits)
//   hwm       : high-water mark of count (CW bits)
//   hwm_clr   : load hwm with the next count value
// -----------------------------------------------------------------------------
module pipe_stage_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   input  logic             flush,
   output logic [CW-1:0]    count,
   output logic [CW-1:0]    hwm,
   input  logic             hwm_clr
);

   // A single-entry buffer still needs a 1-bit pointer; that pointer stays at 0.
   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr_next;
   logic [PW-1:0]    wr_ptr_next;
   logic [CW-1:0]    count_next;
   logic [CW-1:0]    hwm_next;
   logic             push;
   logic             pop;

   // Explicit wrap so that DEPTH does not have to be a power of two.
   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + PW'(1);
   endfunction

   // in_ready depends only on registered count. A pop cannot open a slot in
   // the same cycle, so a full buffer refuses a push even while it drains.
   assign in_ready  = (count < FULL_CNT);
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];

   // A flush drops any word offered in the same cycle.
   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   always_comb begin
      rd_ptr_next = rd_ptr;
      wr_ptr_next = wr_ptr;
      count_next  = count;
      if (flush) begin
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push) wr_ptr_next = wrap_inc(wr_ptr);
         if (pop)  rd_ptr_next = wrap_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
         endcase
      end
      // Clearing loads the post-edge count. Clear plus flush therefore
      // gives a high-water mark of 0.
      if (hwm_clr)
         hwm_next = count_next;
      else
         hwm_next = (count_next > hwm) ? count_next : hwm;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         hwm    <= '0;
      end else begin
         rd_ptr <= rd_ptr_next;
         wr_ptr <= wr_ptr_next;
         count  <= count_next;
         hwm    <= hwm_next;
      end
   end

   // Payload storage is not reset; the control state decides which entries
   // hold valid data.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
module tb_pipe_stage_fifo;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // DEPTH=2 instance
   logic       iv2, ir2, ov2, or2, fl2, hc2;
   logic [7:0] id2, od2;
   logic [1:0] c2, h2;
   // DEPTH=3 instance
   logic       iv3, ir3, ov3, or3, fl3, hc3;
   logic [7:0] id3, od3;
   logic [1:0] c3, h3;
   // DEPTH=4 instance
   logic       iv4, ir4, ov4, or4, fl4, hc4;
   logic [7:0] id4, od4;
   logic [2:0] c4, h4;

   pipe_stage_fifo #(.WIDTH(8), .DEPTH(2)) u_d2 (
      .clock(clock), .reset(reset), .in_valid(iv2), .in_data(id2), .in_ready(ir2),
      .out_valid(ov2), .out_data(od2), .out_ready(or2), .flush(fl2),
      .count(c2), .hwm(h2), .hwm_clr(hc2));

   pipe_stage_fifo #(.WIDTH(8), .DEPTH(3)) u_d3 (
      .clock(clock), .reset(reset), .in_valid(iv3), .in_data(id3), .in_ready(ir3),
      .out_valid(ov3), .out_data(od3), .out_ready(or3), .flush(fl3),
      .count(c3), .hwm(h3), .hwm_clr(hc3));

   pipe_stage_fifo #(.WIDTH(8), .DEPTH(4)) u_d4 (
      .clock(clock), .reset(reset), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
      .out_valid(ov4), .out_data(od4), .out_ready(or4), .flush(fl4),
      .count(c4), .hwm(h4), .hwm_clr(hc4));

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      iv2 = 0; id2 = '0; or2 = 0; fl2 = 0; hc2 = 0;
      iv3 = 0; id3 = '0; or3 = 0; fl3 = 0; hc3 = 0;
      iv4 = 0; id4 = '0; or4 = 0; fl4 = 0; hc4 = 0;
      #12;
      n_cmp++; if (c2 !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", c2); end
      n_cmp++; if (h2 !== 2'd0) begin n_bad++; $display("FAIL reset_hwm: got %0d want 0", h2); end
      n_cmp++; if (ov2 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", ov2); end
      n_cmp++; if (ir2 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", ir2); end
      n_cmp++; if (c4 !== 3'd0 || ir4 !== 1'b1) begin n_bad++; $display("FAIL reset_d4: got count=%0d rdy=%b want 0/1", c4, ir4); end
      reset = 1'b1;
   endtask

   task automatic test_fill();
      // first push right after reset release, shows up one edge later
      iv2 = 1; id2 = 8'h0A; step();
      n_cmp++; if (ov2 !== 1'b1 || od2 !== 8'h0A) begin n_bad++; $display("FAIL first_push: got v=%b d=%h want 1/0a", ov2, od2); end
      n_cmp++; if (c2 !== 2'd1) begin n_bad++; $display("FAIL first_push_count: got %0d want 1", c2); end
      id2 = 8'h0B; step();
      n_cmp++; if (c2 !== 2'd2 || ir2 !== 1'b0) begin n_bad++; $display("FAIL full_state: got count=%0d rdy=%b want 2/0", c2, ir2); end
      n_cmp++; if (od2 !== 8'h0A) begin n_bad++; $display("FAIL full_head: got %h want 0a", od2); end
      id2 = 8'h0C; step();
      n_cmp++; if (c2 !== 2'd2 || od2 !== 8'h0A) begin n_bad++; $display("FAIL push_when_full: got count=%0d d=%h want 2/0a", c2, od2); end
      // pop while full: the offered 0x0C must still be refused
      or2 = 1; step();
      n_cmp++; if (c2 !== 2'd1 || od2 !== 8'h0B) begin n_bad++; $display("FAIL pop_full_no_push: got count=%0d d=%h want 1/0b", c2, od2); end
      iv2 = 0; step();
      n_cmp++; if (c2 !== 2'd0 || ov2 !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got count=%0d v=%b want 0/0", c2, ov2); end
      n_cmp++; if (h2 !== 2'd2) begin n_bad++; $display("FAIL hwm_d2: got %0d want 2", h2); end
      or2 = 0;
   endtask

   task automatic test_simul_push_pop();
      iv2 = 1; id2 = 8'h0A; step();
      iv2 = 1; id2 = 8'h0B; or2 = 1; step();
      n_cmp++; if (c2 !== 2'd1 || od2 !== 8'h0B) begin n_bad++; $display("FAIL simul_push_pop: got count=%0d d=%h want 1/0b", c2, od2); end
      iv2 = 0; or2 = 0;
   endtask

   task automatic test_stream();
      int  sent = 1;
      int  got = 0;
      int  mcnt = 0;
      bit  ordy = 1'b1;
      bit  acc;
      bit  pp;
      for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
         iv3 = (sent <= 10); id3 = 8'(sent); or3 = ordy;
         #1;
         n_cmp++; if (c3 !== 2'(mcnt) || ir3 !== (mcnt < 3)) begin n_bad++; $display("FAIL stream_count: got count=%0d rdy=%b want %0d", c3, ir3, mcnt); end
         acc = iv3 && (mcnt < 3);
         pp  = (mcnt != 0) && ordy;
         if (pp) begin
            n_cmp++; if (od3 !== 8'(got + 1)) begin n_bad++; $display("FAIL stream_order: got %0d want %0d", od3, got + 1); end
            got++;
         end
         if (acc) sent++;
         mcnt = mcnt + int'(acc) - int'(pp);
         step();
         ordy = !ordy;
      end
      n_cmp++; if (got != 10 || sent != 11) begin n_bad++; $display("FAIL stream_complete: got %0d received want 10", got); end
      iv3 = 0; or3 = 0;
   endtask

   task automatic test_flush();
      iv4 = 1; id4 = 8'h01; step();
      id4 = 8'h02; step();
      id4 = 8'h03; step();
      n_cmp++; if (c4 !== 3'd3 || h4 !== 3'd3) begin n_bad++; $display("FAIL pre_flush: got count=%0d hwm=%0d want 3/3", c4, h4); end
      fl4 = 1; iv4 = 1; id4 = 8'h55; or4 = 1; step();
      n_cmp++; if (c4 !== 3'd0 || ov4 !== 1'b0 || ir4 !== 1'b1) begin n_bad++; $display("FAIL flush: got count=%0d v=%b rdy=%b want 0/0/1", c4, ov4, ir4); end
      fl4 = 0; iv4 = 0; or4 = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++; if (ov4 !== 1'b0) begin n_bad++; $display("FAIL flush_dropped: got v=%b d=%h want v=0", ov4, od4); end
      end
      iv4 = 1; id4 = 8'h66; step();
      n_cmp++; if (c4 !== 3'd1 || od4 !== 8'h66) begin n_bad++; $display("FAIL post_flush_push: got count=%0d d=%h want 1/66", c4, od4); end
      n_cmp++; if (h4 !== 3'd3) begin n_bad++; $display("FAIL hwm_after_flush: got %0d want 3", h4); end
      iv4 = 0;
   endtask

   task automatic test_hwm();
      logic [7:0] exp_d [3];
      exp_d[0] = 8'h66; exp_d[1] = 8'h77; exp_d[2] = 8'h88;
      iv4 = 1; id4 = 8'h77; step();
      id4 = 8'h88; step();
      id4 = 8'h99; step();
      iv4 = 0;
      n_cmp++; if (c4 !== 3'd4 || h4 !== 3'd4 || ir4 !== 1'b0) begin n_bad++; $display("FAIL fill4: got count=%0d hwm=%0d rdy=%b want 4/4/0", c4, h4, ir4); end
      or4 = 1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (od4 !== exp_d[i]) begin n_bad++; $display("FAIL drain_order%0d: got %h want %h", i, od4, exp_d[i]); end
         step();
      end
      or4 = 0;
      n_cmp++; if (c4 !== 3'd1 || h4 !== 3'd4 || od4 !== 8'h99) begin n_bad++; $display("FAIL before_clr: got count=%0d hwm=%0d d=%h want 1/4/99", c4, h4, od4); end
      hc4 = 1; step(); hc4 = 0;
      n_cmp++; if (h4 !== 3'd1) begin n_bad++; $display("FAIL hwm_clr: got %0d want 1", h4); end
      hc4 = 1; fl4 = 1; step(); hc4 = 0; fl4 = 0;
      n_cmp++; if (h4 !== 3'd0 || c4 !== 3'd0) begin n_bad++; $display("FAIL clr_flush: got hwm=%0d count=%0d want 0/0", h4, c4); end
      iv4 = 1; id4 = 8'h12; step(); iv4 = 0;
      n_cmp++; if (h4 !== 3'd1) begin n_bad++; $display("FAIL hwm_regrow: got %0d want 1", h4); end
   endtask

   task automatic test_async_reset();
      // d2 holds one word (0x0B) from the previous scenario
      iv2 = 1; id2 = 8'h0C; step(); iv2 = 0;
      n_cmp++; if (c2 !== 2'd2) begin n_bad++; $display("FAIL pre_async: got %0d want 2", c2); end
      #3 reset = 1'b0;
      #1;
      n_cmp++; if (c2 !== 2'd0 || ov2 !== 1'b0) begin n_bad++; $display("FAIL async_reset: got count=%0d v=%b want 0/0", c2, ov2); end
      n_cmp++; if (ir2 !== 1'b1 || h2 !== 2'd0) begin n_bad++; $display("FAIL async_reset_ctl: got rdy=%b hwm=%0d want 1/0", ir2, h2); end
      #2 reset = 1'b1;
      iv2 = 1; id2 = 8'h0D; step(); iv2 = 0;
      n_cmp++; if (c2 !== 2'd1 || od2 !== 8'h0D) begin n_bad++; $display("FAIL after_async: got count=%0d d=%h want 1/0d", c2, od2); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_simul_push_pop();
      test_stream();
      test_flush();
      test_hwm();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
